// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - NUM_REQ-way arbiter sharing one RAM port, registered command and read-response stages
// Optional round-robin arbitration enabled by defining MEM_ARB_ROUND_ROBIN_EN (default: fixed priority, lowest index wins).
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 14,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_in,
    output logic                      mem_write_en,
    input  logic [DATA_W-1:0]         mem_data_out
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0]   winner;
    logic              any_valid;
    logic              accept;

    logic              cmd_valid;
    logic              cmd_write;
    logic [ID_W-1:0]   cmd_id;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cand;

    // Search starts just after the last winner so every requester is reached within NUM_REQ accepts.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                winner    = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (accept) begin
            rr_ptr <= winner;
        end
    end
`else
    // Descending scan so the lowest valid index is the final assignment.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                winner    = ID_W'(i);
                any_valid = 1'b1;
            end
        end
    end
`endif

    assign accept    = any_valid & ~arb_hold & ~rst;
    assign req_ready = accept ? (ONE_HOT0 << winner) : '0;

    // Stage C: capture the granted command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_id    <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (accept) begin
            cmd_valid <= 1'b1;
            cmd_write <= req_write[winner];
            cmd_id    <= winner;
            cmd_addr  <= req_addr[winner*ADDR_W +: ADDR_W];
            cmd_wdata <= req_wdata[winner*DATA_W +: DATA_W];
        end else begin
            cmd_valid <= 1'b0;
        end
    end

    // Stage M: RAM port driven straight from the command register.
    assign mem_addr     = cmd_addr;
    assign mem_data_in  = cmd_wdata;
    assign mem_write_en = cmd_valid & cmd_write;

    // Stage R: register the combinational RAM read and tag it to the issuing requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else if (cmd_valid && !cmd_write) begin
            rsp_valid <= ONE_HOT0 << cmd_id;
            rsp_rdata <= mem_data_out;
        end else begin
            rsp_valid <= '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a 64x14 RAM model
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arb_hold = 1'b0;
    logic [3:0]  req_valid = 4'b0;
    logic [3:0]  req_write = 4'b0;
    logic [23:0] req_addr = '0;
    logic [55:0] req_wdata = '0;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [13:0] rsp_rdata;
    logic [5:0]  mem_addr;
    logic [13:0] mem_data_in;
    logic        mem_write_en;
    logic [13:0] mem_data_out;

    mem_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .arb_hold     (arb_hold),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    logic [13:0] ram [64];
    assign mem_data_out = ram[mem_addr];
    always @(posedge clk) if (mem_write_en) ram[mem_addr] <= mem_data_in;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [3:0]  id;
        logic [13:0] data;
        int          due;
    } rsp_t;
    rsp_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rsp_valid !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 32'h0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_id", 32'(rsp_valid), 32'(e.id));
                chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
                chk("rsp_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    // One cycle of stimulus; an expected read accept queues its response due 2 cycles later.
    task automatic step(input logic hold, input logic [3:0] v, input logic [3:0] w,
                        input logic [23:0] a, input logic [55:0] d,
                        input logic [3:0] exp_ready, input logic [13:0] exp_rdata, input string name);
        rsp_t e;
        @(posedge clk);
        #1;
        arb_hold  = hold;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        chk(name, 32'(req_ready), 32'(exp_ready));
        if ((exp_ready & v & ~w) != 4'b0) begin
            e.id   = exp_ready;
            e.data = exp_rdata;
            e.due  = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input string name);
        step(1'b0, 4'b0, 4'b0, 24'h0, 56'h0, 4'b0, 14'h0, name);
    endtask

    localparam logic [23:0] A_CONT = {6'd13, 6'd12, 6'd11, 6'd10};
    logic [13:0] pre [4] = '{14'h0AAA, 14'h1555, 14'h2D2D, 14'h0F0F};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [3:0] cont_rdy [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] pair_rdy [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
`else
    logic [3:0] cont_rdy [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] pair_rdy [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
`endif

    function automatic logic [13:0] pre_of(input logic [3:0] oh);
        case (oh)
            4'b0001: return pre[0];
            4'b0010: return pre[1];
            4'b0100: return pre[2];
            default: return pre[3];
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 14'h0;

        // Reset with every requester asking.
        req_valid = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_mem_write_en", 32'(mem_write_en), 32'h0);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'b0;

        // Single write then read-back from requester 0.
        step(1'b0, 4'b0001, 4'b0001, 24'd5, 56'h1234, 4'b0001, 14'h0, "wr0_ready");
        step(1'b0, 4'b0001, 4'b0000, 24'd5, 56'h0, 4'b0001, 14'h1234, "rd0_ready");
        chk("wr0_mem_write_en", 32'(mem_write_en), 32'h1);
        chk("wr0_mem_addr", 32'(mem_addr), 32'd5);
        chk("wr0_mem_data_in", 32'(mem_data_in), 32'h1234);
        idle("idle_a");
        chk("rd0_mem_write_en", 32'(mem_write_en), 32'h0);
        idle("idle_b");

        // Write-then-read hazard at the top address.
        step(1'b0, 4'b0100, 4'b0100, {6'd0, 6'd63, 12'd0}, {14'd0, 14'h3FFF, 28'd0}, 4'b0100, 14'h0, "hz_wr_ready");
        step(1'b0, 4'b0010, 4'b0000, {12'd0, 6'd63, 6'd0}, 56'h0, 4'b0010, 14'h3FFF, "hz_rd_ready");
        idle("idle_c");

        // Preload contention addresses through requester 3.
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'b1000, 4'b1000, {6'(10 + i), 18'd0}, {pre[i], 42'd0}, 4'b1000, 14'h0, "pre_ready");
        idle("idle_d");

        // All four reading, held for 8 cycles.
        for (int i = 0; i < 8; i++)
            step(1'b0, 4'b1111, 4'b0000, A_CONT, 56'h0, cont_rdy[i], pre_of(cont_rdy[i]), "cont_ready");
        // Requesters 1 and 3 only.
        for (int i = 0; i < 4; i++)
            step(1'b0, 4'b1010, 4'b0000, A_CONT, 56'h0, pair_rdy[i], pre_of(pair_rdy[i]), "pair_ready");

        // A read in flight completes while arb_hold blocks new grants.
        step(1'b0, 4'b0001, 4'b0000, A_CONT, 56'h0, 4'b0001, pre[0], "hold_pre_ready");
        for (int i = 0; i < 3; i++)
            step(1'b1, 4'b1111, 4'b0000, A_CONT, 56'h0, 4'b0000, 14'h0, "hold_ready");

        // Reset while a read sits in stage M: response dropped, arbitration restarts at requester 0.
        step(1'b0, 4'b0100, 4'b0000, A_CONT, 56'h0, 4'b0100, 14'h0, "rst_mid_ready");
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("rst_mid_req_ready", 32'(req_ready), 32'h0);
        chk("rst_mid_mem_write_en", 32'(mem_write_en), 32'h0);
        @(negedge clk);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'b0;
        step(1'b0, 4'b1111, 4'b0000, A_CONT, 56'h0, 4'b0001, pre[0], "post_rst_ready");
        idle("idle_e");
        idle("idle_f");
        idle("idle_g");

        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
